// File: rtl/usb_stream_mux.sv
// ---------------------------------------------------------------------------
// usb_stream_mux
//
// Multiplexes NCH byte streams onto an FT245 synchronous-FIFO write port.
// Each channel owns a DEPTH-byte FIFO.  A round-robin scheduler picks the
// next non-empty channel. It emits one header byte {len-1, chan}, followed by
// up to MAXBURST data bytes from that channel.
//
// Parameters
//   NCH      number of input channels (1..16)
//   DEPTH    per-channel FIFO depth in bytes (power of 2, >= 4)
//   MAXBURST maximum data bytes per frame (1..16)
//
// Ports
//   mclk           single clock, rising edge
//   reset          asynchronous, active-high
//   ch_data        channel i byte on bits [8i+7:8i]
//   ch_wr          channel i write strobe, one byte per cycle
//   ch_have_space  channel i FIFO not full
//   ch_overflow    sticky: a channel i write was dropped
//   usb_d          FT245 data bus
//   usb_txe_n      FT245 transmit FIFO has space (active-low)
//   usb_wr_n       FT245 write strobe (active-low)
//   usb_oe_n       FT245 output enable, held high (write-only block)
// ---------------------------------------------------------------------------
module usb_stream_mux #(
  parameter int NCH      = 2,
  parameter int DEPTH    = 16,
  parameter int MAXBURST = 8
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [8*NCH-1:0] ch_data,
  input  logic [NCH-1:0]   ch_wr,
  output logic [NCH-1:0]   ch_have_space,
  output logic [NCH-1:0]   ch_overflow,
  output logic [7:0]       usb_d,
  input  logic             usb_txe_n,
  output logic             usb_wr_n,
  output logic             usb_oe_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     chan_q, chan_d;
  logic [3:0]     last_q, last_d;
  logic [3:0]     hlen_q, hlen_d;   // frame length minus one, as sent in the header
  logic [4:0]     rem_q, rem_d;     // data bytes still to be accepted in this frame

  logic [AW-1:0]  wr_ptr_q [NCH];
  logic [AW-1:0]  wr_ptr_d [NCH];
  logic [AW-1:0]  rd_ptr_q [NCH];
  logic [AW-1:0]  rd_ptr_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [NCH-1:0] ovf_q, ovf_d;

  logic [7:0]     fifo_mem [NCH][DEPTH];

  logic [NCH-1:0] wr_en;
  logic [NCH-1:0] pop;
  logic           accept;
  logic           found;
  logic [3:0]     sel;
  logic [CW-1:0]  sel_cnt;
  logic [7:0]     head;

  // Frame length is the channel fill level clipped to MAXBURST; returned
  // minus one so it drops straight into the 4-bit header field.
  function automatic logic [3:0] burst_len_m1(input logic [CW-1:0] c);
    int n;
    n = int'(c);
    if (n > MAXBURST) n = MAXBURST;
    return 4'(n - 1);
  endfunction

  // A byte moves across the USB port only when both strobes are low.
  always_comb begin
    accept = (state_q != S_IDLE) && !usb_txe_n;
  end

  // ---- channel FIFOs ------------------------------------------------------
  // Fullness is judged on the registered count, so a write into a full FIFO
  // is dropped even when the same edge pops a byte out of it.
  always_comb begin
    wr_en = '0;
    pop   = '0;
    ovf_d = ovf_q;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i]    = ch_wr[i] && (cnt_q[i] < DEPTH_C);
      pop[i]      = accept && (state_q == S_DATA) && (chan_q == 4'(i));
      wr_ptr_d[i] = wr_en[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]   ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (wr_en[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!wr_en[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (ch_wr[i] && !wr_en[i]) begin
        ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_en[i]) begin
        fifo_mem[i][wr_ptr_q[i]] <= ch_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    head = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == 4'(i)) begin
        head = fifo_mem[i][rd_ptr_q[i]];
      end
    end
  end

  always_comb begin
    ch_have_space = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_have_space[i] = (cnt_q[i] < DEPTH_C);
    end
  end

  assign ch_overflow = ovf_q;

  // ---- round-robin search -------------------------------------------------
  // First pass looks above the last served channel, second pass wraps to the
  // bottom; this yields the first non-empty channel from last_served+1.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && (cnt_q[i] != '0) && (4'(i) > last_q)) begin
        found   = 1'b1;
        sel     = 4'(i);
        sel_cnt = cnt_q[i];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && (cnt_q[i] != '0) && (4'(i) <= last_q)) begin
        found   = 1'b1;
        sel     = 4'(i);
        sel_cnt = cnt_q[i];
      end
    end
  end

  // ---- frame FSM ----------------------------------------------------------
  // A frame is only committed while the host has space, so bytes that
  // arrive while usb_txe_n is high accumulate into one longer frame.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    hlen_d  = hlen_q;
    rem_d   = rem_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (found && !usb_txe_n) begin
          chan_d  = sel;
          hlen_d  = burst_len_m1(sel_cnt);
          rem_d   = {1'b0, hlen_d} + 5'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            last_d  = chan_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      S_HDR:   usb_d = {hlen_q, chan_q};
      S_DATA:  usb_d = head;
      default: usb_d = 8'h00;
    endcase
  end

  assign usb_wr_n = !((state_q == S_HDR) || (state_q == S_DATA));
  assign usb_oe_n = 1'b1;

  // ---- state registers ----------------------------------------------------
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      hlen_q  <= '0;
      rem_q   <= '0;
      last_q  <= 4'(NCH - 1);
      ovf_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      hlen_q  <= hlen_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_usb_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_usb_stream_mux
//
// Directed bench for usb_stream_mux (NCH=2, DEPTH=16, MAXBURST=8).
// A negedge monitor records every byte that will be accepted at the next
// rising edge; each scenario task compares that record, or the live
// outputs, against hand-computed values.
// ---------------------------------------------------------------------------
module tb_usb_stream_mux;

  localparam int NCH      = 2;
  localparam int DEPTH    = 16;
  localparam int MAXBURST = 8;

  logic             mclk;
  logic             reset;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_wr;
  logic [NCH-1:0]   ch_have_space;
  logic [NCH-1:0]   ch_overflow;
  logic [7:0]       usb_d;
  logic             usb_txe_n;
  logic             usb_wr_n;
  logic             usb_oe_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] capq[$];
  logic [7:0] exp[$];

  usb_stream_mux #(.NCH(NCH), .DEPTH(DEPTH), .MAXBURST(MAXBURST)) dut (
    .mclk          (mclk),
    .reset         (reset),
    .ch_data       (ch_data),
    .ch_wr         (ch_wr),
    .ch_have_space (ch_have_space),
    .ch_overflow   (ch_overflow),
    .usb_d         (usb_d),
    .usb_txe_n     (usb_txe_n),
    .usb_wr_n      (usb_wr_n),
    .usb_oe_n      (usb_oe_n)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Inputs change 1ns after the rising edge, so what is seen here holds
  // through the next rising edge.
  always @(negedge mclk) begin
    if (!reset && usb_wr_n === 1'b0 && usb_txe_n === 1'b0) capq.push_back(usb_d);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic drain(input int n);
    usb_txe_n = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL reset_wr_n: got %b want 1", usb_wr_n); end
    vectors++; if (usb_oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n: got %b want 1", usb_oe_n); end
    vectors++; if (usb_d !== 8'h00) begin miscompares++; $display("FAIL reset_usb_d: got %h want 00", usb_d); end
    vectors++; if (ch_have_space !== 2'b11) begin miscompares++; $display("FAIL reset_space: got %b want 11", ch_have_space); end
    vectors++; if (ch_overflow !== 2'b00) begin miscompares++; $display("FAIL reset_ovf: got %b want 00", ch_overflow); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle: got %b want 1", usb_wr_n); end
  endtask

  task automatic test_header_seq();
    usb_txe_n = 1'b1;
    capq.delete();
    ch_data[7:0] = 8'h11; ch_wr = 2'b01; tick();
    ch_data[7:0] = 8'h22; tick();
    ch_data[7:0] = 8'h33; tick();
    ch_wr = 2'b00;
    usb_txe_n = 1'b0;
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL hdrseq_idle: got %b want 1", usb_wr_n); end
    tick();
    vectors++; if (usb_wr_n !== 1'b0 || usb_d !== 8'h20) begin miscompares++; $display("FAIL hdrseq_hdr: got wr_n=%b d=%h want 0/20", usb_wr_n, usb_d); end
    tick();
    vectors++; if (usb_wr_n !== 1'b0 || usb_d !== 8'h11) begin miscompares++; $display("FAIL hdrseq_data0: got wr_n=%b d=%h want 0/11", usb_wr_n, usb_d); end
    repeat (3) tick();
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL hdrseq_end: got %b want 1", usb_wr_n); end
    exp.delete();
    exp.push_back(8'h20); exp.push_back(8'h11); exp.push_back(8'h22); exp.push_back(8'h33);
    vectors++; if (capq.size() != exp.size()) begin miscompares++; $display("FAIL hdrseq_len: got %0d want %0d", capq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= capq.size()) begin miscompares++; $display("FAIL hdrseq_byte%0d: got none want %h", i, exp[i]); end
      else if (capq[i] !== exp[i]) begin miscompares++; $display("FAIL hdrseq_byte%0d: got %h want %h", i, capq[i], exp[i]); end
    end
  endtask

  task automatic test_latency();
    usb_txe_n = 1'b0;
    ch_data[15:8] = 8'h5A; ch_wr = 2'b10; tick();
    ch_wr = 2'b00;
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL lat_k: got %b want 1", usb_wr_n); end
    tick();
    vectors++; if (usb_wr_n !== 1'b0 || usb_d !== 8'h01) begin miscompares++; $display("FAIL lat_k1: got wr_n=%b d=%h want 0/01", usb_wr_n, usb_d); end
    tick();
    vectors++; if (usb_wr_n !== 1'b0 || usb_d !== 8'h5A) begin miscompares++; $display("FAIL lat_k2: got wr_n=%b d=%h want 0/5a", usb_wr_n, usb_d); end
    tick();
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL lat_k3: got %b want 1", usb_wr_n); end
  endtask

  task automatic test_round_robin();
    usb_txe_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      ch_data = {8'(8'h80 + j), 8'(j)};
      ch_wr = 2'b11;
      tick();
    end
    ch_wr = 2'b00;
    vectors++; if (ch_have_space !== 2'b11) begin miscompares++; $display("FAIL rr_space: got %b want 11", ch_have_space); end
    capq.delete();
    drain(40);
    exp.delete();
    exp.push_back(8'h70); for (int j = 0; j < 8; j++) exp.push_back(8'(j));
    exp.push_back(8'h71); for (int j = 0; j < 8; j++) exp.push_back(8'(8'h80 + j));
    exp.push_back(8'h30); for (int j = 8; j < 12; j++) exp.push_back(8'(j));
    exp.push_back(8'h31); for (int j = 8; j < 12; j++) exp.push_back(8'(8'h80 + j));
    vectors++; if (capq.size() != exp.size()) begin miscompares++; $display("FAIL rr_len: got %0d want %0d", capq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= capq.size()) begin miscompares++; $display("FAIL rr_byte%0d: got none want %h", i, exp[i]); end
      else if (capq[i] !== exp[i]) begin miscompares++; $display("FAIL rr_byte%0d: got %h want %h", i, capq[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    usb_txe_n = 1'b1;
    for (int j = 0; j < 17; j++) begin
      ch_data[7:0] = 8'(8'h40 + j);
      ch_wr = 2'b01;
      tick();
      if (j == 15) begin
        vectors++; if (ch_have_space !== 2'b10) begin miscompares++; $display("FAIL ovf_full_space: got %b want 10", ch_have_space); end
        vectors++; if (ch_overflow !== 2'b00) begin miscompares++; $display("FAIL ovf_early: got %b want 00", ch_overflow); end
      end
    end
    ch_wr = 2'b00;
    vectors++; if (ch_have_space !== 2'b10) begin miscompares++; $display("FAIL ovf_space: got %b want 10", ch_have_space); end
    vectors++; if (ch_overflow !== 2'b01) begin miscompares++; $display("FAIL ovf_flag: got %b want 01", ch_overflow); end
    capq.delete();
    drain(30);
    exp.delete();
    exp.push_back(8'h70); for (int j = 0; j < 8; j++) exp.push_back(8'(8'h40 + j));
    exp.push_back(8'h70); for (int j = 8; j < 16; j++) exp.push_back(8'(8'h40 + j));
    vectors++; if (capq.size() != exp.size()) begin miscompares++; $display("FAIL ovf_len: got %0d want %0d", capq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= capq.size()) begin miscompares++; $display("FAIL ovf_byte%0d: got none want %h", i, exp[i]); end
      else if (capq[i] !== exp[i]) begin miscompares++; $display("FAIL ovf_byte%0d: got %h want %h", i, capq[i], exp[i]); end
    end
    vectors++; if (ch_overflow !== 2'b01) begin miscompares++; $display("FAIL ovf_sticky: got %b want 01", ch_overflow); end
    vectors++; if (ch_have_space !== 2'b11) begin miscompares++; $display("FAIL ovf_drained_space: got %b want 11", ch_have_space); end
  endtask

  task automatic test_txe_toggle();
    int sent[2];
    int rcv[2];
    int cycles;
    int p;
    int ch;
    int len;
    logic bad;
    logic [7:0] hdr;
    logic [7:0] want;
    sent = '{0, 0};
    rcv = '{0, 0};
    cycles = 0;
    capq.delete();
    while ((sent[0] < 20 || sent[1] < 20) && cycles < 2000) begin
      ch_wr = 2'b00;
      for (int c = 0; c < NCH; c++) begin
        if (sent[c] < 20 && ch_have_space[c] && $urandom_range(0, 3) != 0) begin
          ch_data[8*c +: 8] = (c == 0) ? 8'(sent[c]) : 8'(8'h80 + sent[c]);
          ch_wr[c] = 1'b1;
          sent[c]++;
        end
      end
      usb_txe_n = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    ch_wr = 2'b00;
    vectors++; if (cycles >= 2000) begin miscompares++; $display("FAIL tog_timeout: got %0d cycles want <2000", cycles); end
    drain(120);
    p = 0;
    bad = 1'b0;
    while (p < capq.size() && !bad) begin
      hdr = capq[p];
      ch = int'(hdr[3:0]);
      len = int'(hdr[7:4]) + 1;
      p++;
      vectors++;
      if (ch >= NCH || len > MAXBURST) begin
        miscompares++; bad = 1'b1;
        $display("FAIL tog_header: got %h want chan<2 len<=8", hdr);
      end else begin
        for (int k = 0; k < len; k++) begin
          if (p >= capq.size()) begin
            vectors++; miscompares++; bad = 1'b1;
            $display("FAIL tog_truncated: got %0d bytes want %0d more", k, len - k);
            break;
          end
          want = (ch == 0) ? 8'(rcv[0]) : 8'(8'h80 + rcv[1]);
          vectors++;
          if (capq[p] !== want) begin miscompares++; $display("FAIL tog_ch%0d_byte%0d: got %h want %h", ch, rcv[ch], capq[p], want); end
          rcv[ch]++;
          p++;
        end
      end
    end
    vectors++; if (rcv[0] != 20) begin miscompares++; $display("FAIL tog_ch0_count: got %0d want 20", rcv[0]); end
    vectors++; if (rcv[1] != 20) begin miscompares++; $display("FAIL tog_ch1_count: got %0d want 20", rcv[1]); end
    vectors++; if (ch_overflow !== 2'b01) begin miscompares++; $display("FAIL tog_ovf: got %b want 01", ch_overflow); end
  endtask

  task automatic test_reset_mid_frame();
    usb_txe_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      ch_data[7:0] = 8'(8'h60 + j);
      ch_wr = 2'b01;
      tick();
    end
    ch_wr = 2'b00;
    usb_txe_n = 1'b0;
    repeat (4) tick();
    vectors++; if (usb_wr_n !== 1'b0 || usb_d !== 8'h62) begin miscompares++; $display("FAIL rst_mid_data: got wr_n=%b d=%h want 0/62", usb_wr_n, usb_d); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_wr_n: got %b want 1", usb_wr_n); end
    vectors++; if (usb_d !== 8'h00) begin miscompares++; $display("FAIL rst_mid_usb_d: got %h want 00", usb_d); end
    vectors++; if (ch_have_space !== 2'b11) begin miscompares++; $display("FAIL rst_mid_space: got %b want 11", ch_have_space); end
    vectors++; if (ch_overflow !== 2'b00) begin miscompares++; $display("FAIL rst_mid_ovf: got %b want 00", ch_overflow); end
    tick();
    vectors++; if (usb_wr_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_hold: got %b want 1", usb_wr_n); end
    reset = 1'b0;
    capq.delete();
    ch_data[15:8] = 8'hAB; ch_wr = 2'b10; tick();
    ch_wr = 2'b00;
    repeat (5) tick();
    exp.delete();
    exp.push_back(8'h01); exp.push_back(8'hAB);
    vectors++; if (capq.size() != exp.size()) begin miscompares++; $display("FAIL rst_after_len: got %0d want %0d", capq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= capq.size()) begin miscompares++; $display("FAIL rst_after_byte%0d: got none want %h", i, exp[i]); end
      else if (capq[i] !== exp[i]) begin miscompares++; $display("FAIL rst_after_byte%0d: got %h want %h", i, capq[i], exp[i]); end
    end
  endtask

  initial begin
    reset     = 1'b0;
    ch_wr     = '0;
    ch_data   = '0;
    usb_txe_n = 1'b1;
    #1;
    reset = 1'b1;
    test_reset();
    test_header_seq();
    test_latency();
    test_round_robin();
    test_overflow();
    test_txe_toggle();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_stream_mux.md
USB_STREAM_MUX -- requirements
Module: usb_stream_mux

Interface
REQ-001 SHALL have parameter NCH, default 2, number of input channels (1..16).
REQ-002 SHALL have parameter DEPTH, default 16, per-channel FIFO depth in bytes (power of 2, >=4).
REQ-003 SHALL have parameter MAXBURST, default 8, maximum data bytes per frame (1..16).
REQ-004 SHALL have port mclk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ch_data  input  8*NCH  channel i byte on bits [8i+7:8i].
REQ-007 SHALL have port ch_wr  input  NCH  channel i write strobe, one byte per cycle.
REQ-008 SHALL have port ch_have_space  output  NCH  channel i FIFO not full.
REQ-009 SHALL have port ch_overflow  output  NCH  sticky: a channel i write was dropped.
REQ-010 SHALL have port usb_d  output  8  FT245 synchronous-FIFO data bus.
REQ-011 SHALL have port usb_txe_n  input  1  FT245 transmit FIFO has space, active-low.
REQ-012 SHALL have port usb_wr_n  output  1  FT245 write strobe, active-low.
REQ-013 SHALL have port usb_oe_n  output  1  held 1 (write-only block).

Function
REQ-014 SHALL give each channel a DEPTH-byte FIFO; ch_have_space[i] = (count_i < DEPTH), combinational from the registered count.
REQ-015 SHALL accept a channel write only when ch_wr[i]=1 and count_i < DEPTH at that edge; a write while full is dropped even if a read of that FIFO happens in the same cycle.
REQ-016 SHALL set ch_overflow[i] on a dropped write and hold it until reset.
REQ-017 SHALL count bytes as a USB transfer only at a rising edge where usb_wr_n=0 and usb_txe_n=0 ("accept"); otherwise usb_d and usb_wr_n hold unchanged.
REQ-018 SHALL run states IDLE, HDR, DATA; usb_wr_n=0 exactly in HDR and DATA, decoded from registered state.
REQ-019 IDLE: SHALL round-robin search starting at channel (last_served+1) mod NCH and, if a non-empty FIFO is found, latch chan and len = min(count_chan, MAXBURST), then go to HDR.
REQ-020 HDR: usb_d = {len-1 [3:0], chan [3:0]}; on accept SHALL go to DATA.
REQ-021 DATA: usb_d = head byte of FIFO chan; on accept SHALL pop one byte and decrement the remaining count; on the accept of the last byte SHALL set last_served=chan and go to IDLE.
REQ-022 SHALL keep the latched len fixed even if the channel receives more bytes during the frame.
REQ-023 SHALL support simultaneous write and pop on one FIFO (count unchanged), including the pointer wrap from DEPTH-1 to 0.
REQ-024 Latency: a byte written into all-empty FIFOs at edge k, with usb_txe_n=0, SHALL give HDR at edge k+1, header accepted at k+2, data accepted at k+3.
REQ-025 SHALL return to IDLE for one cycle between frames (no back-to-back HDR).
REQ-026 SHALL let usb_txe_n deassert mid-frame and resume the same byte afterwards with no loss or duplication.

Reset
REQ-027 On reset SHALL immediately: state IDLE, usb_wr_n=1, usb_oe_n=1, usb_d=0, all FIFOs empty, ch_have_space all 1, ch_overflow all 0, last_served=NCH-1 (first search starts at channel 0).
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no further accepts; the bytes remaining in the frame are discarded.

Verification
REQ-029 NCH=2, usb_txe_n=0; ch0 writes 0x11,0x22,0x33 -> USB sequence 0x20,0x11,0x22,0x33, first accept 2 cycles after the last write edge.
REQ-030 Both channels preloaded with 12 bytes each, MAXBURST=8 -> frames ch0(8), ch1(8), ch0(4), ch1(4); headers 0x70,0x71,0x30,0x31.
REQ-031 ch0 written with 17 consecutive bytes (DEPTH=16) and no USB drain (usb_txe_n=1) -> ch_have_space[0]=0 after 16, byte 17 dropped, ch_overflow[0]=1; ch1 unaffected.
REQ-032 usb_txe_n toggling pseudo-randomly while both channels stream -> the decoded frames reproduce each channel's byte order exactly with no gaps or duplicates.
REQ-033 Reset asserted during DATA of a 6-byte frame -> usb_wr_n=1 with no clock edge needed, all FIFOs empty; after release a new ch1 byte 0xAB yields 0x01,0xAB.
